ram_sync_be: RTL and testbench
==============================

// Module: ram_sync_be
// PURPOSE
//  Parametrised single-port synchronous RAM, successor to the fixed 128x8 RAM. Adds configurable
//  width/depth, byte-lane write enables, registered read with valid strobe, selectable
//  read-during-write mode and a post-reset memory-clear sequencer. Serves as the general
//  scratch/data memory for later datapath exercises.
// PARAMETERS
//  DATA_W     8      word width in bits; multiple of 8
//  ADDR_W     7      address width
//  DEPTH      128    number of words; 1..2**ADDR_W
//  RDW_MODE   0      read-during-write same address: 0 = read-first (old data), 1 = write-first (new)
//  CLEAR_EN   1      1 = clear all words to CLEAR_VAL after reset; 0 = no clear, contents undefined
//  CLEAR_VAL  0      fill value used by the clear sequence (DATA_W bits)
// PORTS
//  clk       in   1          clock, all logic on rising edge
//  rst       in   1          synchronous reset, active-high
//  we        in   1          write request
//  re        in   1          read request
//  addr      in   ADDR_W     word address for read and write
//  data_in   in   DATA_W     write data
//  byte_en   in   DATA_W/8   byte-lane write mask, bit i -> data_in[8i+7:8i]
//  data_out  out  DATA_W     registered read data
//  rd_valid  out  1          1-cycle strobe: data_out updated this cycle
//  busy      out  1          clear sequence in progress; requests ignored
//  addr_err  out  1          1-cycle strobe: request addressed a word >= DEPTH
// BEHAVIOUR
//  Reset (rst=1 at edge): data_out=0, rd_valid=0, addr_err=0, clear counter=0;
//   busy=1 if CLEAR_EN else 0. Memory array itself is not reset, only cleared by the sequencer.
//  FSM: CLEAR, RUN. Reset -> CLEAR if CLEAR_EN, else RUN.
//   CLEAR: one word per cycle, mem[cnt]<=CLEAR_VAL, cnt++; after writing DEPTH-1 -> RUN.
//   Clear takes exactly DEPTH cycles; busy falls on the edge that enters RUN.
//   we/re during CLEAR ignored: no write, rd_valid=0, addr_err=0, data_out held.
//   rst during CLEAR restarts at word 0.
//  Write (RUN, we=1, addr<DEPTH): on edge, lane i of mem[addr] <= data_in lane i where byte_en[i]=1;
//   other lanes keep old value. byte_en=0 -> no change. Write visible to reads from next cycle.
//  Read (RUN, re=1, addr<DEPTH): latency 1; edge N samples addr, after edge N data_out=mem[addr],
//   rd_valid=1 for that cycle only. No read -> data_out holds last value, rd_valid=0.
//  Read+write same cycle (same addr): RDW_MODE=0 -> data_out=old word;
//   RDW_MODE=1 -> data_out=merged word (new lanes where byte_en=1, old elsewhere).
//  Out of range (addr>=DEPTH, RUN, we|re): write dropped, data_out held, rd_valid=0,
//   addr_err=1 for one cycle. Never aliases/wraps onto valid words.
//  Back-to-back reads each edge: one rd_valid per request, no bubbles.
// STRUCTURE
//  Package ram_pkg: typedef of FSM state {CLEAR, RUN}; function byte_merge(old,new,be); localparam
//   BE_W = DATA_W/8 derivation rule.
//  Sub-module ram_clear_seq: counter + FSM, outputs busy, clr_we, clr_addr; top muxes write port.
//  Array inferred as reg [DATA_W-1:0] mem[0:DEPTH-1]; one write port, one registered read.
//  Elaboration check: DATA_W%8!=0 or DEPTH>2**ADDR_W -> $error.
// TESTING
//  1 Reset, CLEAR_EN=1, DEPTH=128 -> busy=1 for 128 cycles, then 0; read addr 0 and 127 -> 0x00.
//  2 we=1 addr=10 data=0xAA, then addr=20 data=0x55; re addr 10 -> 0xAA, addr 20 -> 0x55, rd_valid 1 cycle each.
//  3 DATA_W=32: write 0x11223344 @5 be=4'hF, then 0xAABBCCDD be=4'b0101 -> read @5 = 0x11BB33DD.
//  4 Same-cycle re+we addr 7 (old 0x12, new 0x34): RDW_MODE=0 -> 0x12; RDW_MODE=1 -> 0x34; mem=0x34 after.
//  5 DEPTH=100, ADDR_W=7: write addr 110 -> addr_err pulse, mem[110-100] unchanged; read 110 -> rd_valid=0.
//  6 rst asserted at clear cycle 50 -> sequence restarts, busy stays high 128 more cycles; we during busy ignored.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled synchronous RAM and its clear sequencer.
package ram_pkg;

    // Operating state of the RAM: filling every word after reset, or serving requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

    // Widest word the merge helper supports; callers zero-extend into it and truncate back.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // One byte-enable bit per 8-bit lane of the data word.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Replace the lanes of old_word selected by be with the matching lanes of new_word.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, one per cycle, and then
// hands the write port back to normal traffic. With CLEAR_EN=0 it starts directly in RUN.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 128,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam ram_state_t        START_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;

    ram_state_t        state_q;
    ram_state_t        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // State and clear-address registers; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one word cleared per cycle, leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign busy      = (state_q == ST_CLEAR);
    assign clr_addr  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with byte-lane write enables, a registered read port with a
// one-cycle valid strobe, selectable read-during-write behaviour and a post-reset clear.
//
// Request semantics: we/re are single-cycle requests sampled on the rising edge; there is no
// back-pressure. A request is accepted only when the clear sequence is idle and addr < DEPTH.
// Each accepted read yields exactly one rd_valid pulse one cycle later; a request to an
// address >= DEPTH yields exactly one addr_err pulse and touches nothing else.
module ram_sync_be
    import ram_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter int                DEPTH     = 128,
    parameter int                RDW_MODE  = 0,
    parameter int                CLEAR_EN  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int              BE_W    = be_width(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Reject configurations the lane logic or address decode cannot represent.
    if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_param_check
        $error("ram_sync_be: DATA_W must be a multiple of 8 and DEPTH must lie in 1..2**ADDR_W");
    end

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              seq_state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              run;
    logic              in_range;
    logic              wr_fire;
    logic              rd_fire;
    logic              req_err;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;

    ram_clear_seq #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .CLEAR_EN (CLEAR_EN)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state_dbg (seq_state)
    );

    // Request decode: accept only in RUN outside reset; the wide compare stops aliasing.
    always_comb begin
        run         = (seq_state == ST_RUN) && !rst;
        in_range    = ({1'b0, addr} < DEPTH_L);
        wr_fire     = run && we && in_range;
        rd_fire     = run && re && in_range;
        req_err     = run && (we || re) && !in_range;
        old_word    = in_range ? mem[addr] : '0;
        merged_word = DATA_W'(byte_merge(MAX_DATA_W'(old_word),
                                         MAX_DATA_W'(data_in),
                                         MAX_BE_W'(byte_en)));
    end

    // Single write port: the clear sequencer owns it while busy, otherwise lane-masked writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byte_en[i]) begin
                    mem[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Registered read with valid/error strobes; same-address write is forwarded in write-first mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            addr_err <= req_err;
            if (rd_fire) begin
                if (RDW_MODE != 0 && wr_fire) begin
                    data_out <= merged_word;
                end else begin
                    data_out <= old_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sync_be.sv
// Bench for ram_sync_be: two instances share one stimulus stream.
//   a: 32-bit, DEPTH=100, read-first     b: 32-bit, DEPTH=128, write-first
module tb_ram_sync_be;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [6:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  byte_en;

  logic [31:0] dout_a, dout_b;
  logic        valid_a, valid_b, busy_a, busy_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = instance a, 1 = instance b
  logic [31:0] m_mem [0:1][0:127];
  int          m_clr [0:1];
  logic [31:0] m_dout [0:1];
  logic        m_valid [0:1];
  logic        m_err [0:1];

  logic [31:0] exp_q [$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  ram_sync_be #(
    .DATA_W(32), .ADDR_W(7), .DEPTH(100), .RDW_MODE(0), .CLEAR_EN(1), .CLEAR_VAL(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .byte_en(byte_en), .data_out(dout_a), .rd_valid(valid_a), .busy(busy_a), .addr_err(err_a)
  );

  ram_sync_be #(
    .DATA_W(32), .ADDR_W(7), .DEPTH(128), .RDW_MODE(1), .CLEAR_EN(1), .CLEAR_VAL(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .byte_en(byte_en), .data_out(dout_b), .rd_valid(valid_b), .busy(busy_b), .addr_err(err_b)
  );

  // ---------------- reference model ----------------
  // Behaviour at one rising edge for both instances, from the memory's rules.
  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [6:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 2; k++) begin
      int          dep;
      logic [31:0] old_w;
      logic [31:0] new_w;
      dep = (k == 0) ? 100 : 128;
      if (r) begin
        m_clr[k] = dep;
        m_dout[k] = 32'h0;
        m_valid[k] = 1'b0;
        m_err[k] = 1'b0;
      end else if (m_clr[k] > 0) begin
        m_clr[k] = m_clr[k] - 1;
        if (m_clr[k] == 0) begin
          for (int j = 0; j < dep; j++) m_mem[k][j] = 32'h0;
        end
        m_valid[k] = 1'b0;
        m_err[k] = 1'b0;
      end else if (int'(a) < dep) begin
        old_w = m_mem[k][a];
        new_w = old_w;
        for (int l = 0; l < 4; l++) begin
          if (be[l]) new_w[8*l +: 8] = d[8*l +: 8];
        end
        m_err[k] = 1'b0;
        m_valid[k] = rd;
        if (rd) m_dout[k] = (k == 1 && w) ? new_w : old_w;
        if (w) m_mem[k][a] = new_w;
      end else begin
        m_err[k] = w | rd;
        m_valid[k] = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [6:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    rst = r; we = w; re = rd; addr = a; data_in = d; byte_en = be;
    @(posedge clk);
    model_edge(r, w, rd, a, d, be);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 4'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int n_busy_a;
    int n_busy_b;
    cycle(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 4'h0);
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy_b actual=%b expected=1", busy_b); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a actual=%b expected=1", busy_a); end
    checks++; if (dout_b !== 32'h0) begin errors++; $display("FAIL reset_dout_b actual=%h expected=0", dout_b); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b actual=%b expected=0", valid_b); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL reset_err_b actual=%b expected=0", err_b); end
    n_busy_a = 1;
    n_busy_b = 1;
    for (int i = 0; i < 140; i++) begin
      idle(1);
      if (busy_a === 1'b1) n_busy_a++;
      if (busy_b === 1'b1) n_busy_b++;
      checks++;
      if (busy_a !== (m_clr[0] > 0)) begin
        errors++; $display("FAIL clear_busy_a cycle=%0d actual=%b expected=%b", i, busy_a, m_clr[0] > 0);
      end
    end
    checks++; if (n_busy_b != 128) begin errors++; $display("FAIL clear_len_b actual=%0d expected=128", n_busy_b); end
    checks++; if (n_busy_a != 100) begin errors++; $display("FAIL clear_len_a actual=%0d expected=100", n_busy_a); end
    cycle(1'b0, 1'b0, 1'b1, 7'd0, 32'h0, 4'h0);
    checks++; if (valid_b !== 1'b1 || dout_b !== 32'h0) begin errors++; $display("FAIL cleared_word0 actual=%b/%h expected=1/0", valid_b, dout_b); end
    cycle(1'b0, 1'b0, 1'b1, 7'd127, 32'h0, 4'h0);
    checks++; if (valid_b !== 1'b1 || dout_b !== 32'h0) begin errors++; $display("FAIL cleared_word127 actual=%b/%h expected=1/0", valid_b, dout_b); end
    checks++; if (err_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL a_read127_err actual=%b/%b expected=1/0", err_a, valid_a); end
  endtask

  task automatic test_write_read;
    cycle(1'b0, 1'b1, 1'b0, 7'd10, 32'hAA, 4'hF);
    cycle(1'b0, 1'b1, 1'b0, 7'd20, 32'h55, 4'hF);
    cycle(1'b0, 1'b0, 1'b1, 7'd10, 32'h0, 4'h0);
    checks++; if (dout_a !== 32'hAA || valid_a !== 1'b1) begin errors++; $display("FAIL rd10_a actual=%h/%b expected=aa/1", dout_a, valid_a); end
    checks++; if (dout_b !== 32'hAA || valid_b !== 1'b1) begin errors++; $display("FAIL rd10_b actual=%h/%b expected=aa/1", dout_b, valid_b); end
    cycle(1'b0, 1'b0, 1'b1, 7'd20, 32'h0, 4'h0);
    checks++; if (dout_b !== 32'h55 || valid_b !== 1'b1) begin errors++; $display("FAIL rd20_b actual=%h/%b expected=55/1", dout_b, valid_b); end
    idle(1);
    checks++; if (valid_b !== 1'b0 || dout_b !== 32'h55) begin errors++; $display("FAIL hold_b actual=%b/%h expected=0/55", valid_b, dout_b); end
  endtask

  task automatic test_byte_en;
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h11223344, 4'hF);
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'hAABBCCDD, 4'b0101);
    cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'h0, 4'h0);
    checks++; if (dout_a !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge_a actual=%h expected=11bb33dd", dout_a); end
    checks++; if (dout_b !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge_b actual=%h expected=11bb33dd", dout_b); end
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'hFFFFFFFF, 4'h0);
    cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'h0, 4'h0);
    checks++; if (dout_b !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_b actual=%h expected=11bb33dd", dout_b); end
  endtask

  task automatic test_rdw;
    cycle(1'b0, 1'b1, 1'b0, 7'd7, 32'h12, 4'hF);
    cycle(1'b0, 1'b1, 1'b1, 7'd7, 32'h34, 4'hF);
    checks++; if (dout_a !== 32'h12 || valid_a !== 1'b1) begin errors++; $display("FAIL rdw_old_a actual=%h/%b expected=12/1", dout_a, valid_a); end
    checks++; if (dout_b !== 32'h34 || valid_b !== 1'b1) begin errors++; $display("FAIL rdw_new_b actual=%h/%b expected=34/1", dout_b, valid_b); end
    cycle(1'b0, 1'b0, 1'b1, 7'd7, 32'h0, 4'h0);
    checks++; if (dout_a !== 32'h34) begin errors++; $display("FAIL rdw_after_a actual=%h expected=34", dout_a); end
    cycle(1'b0, 1'b1, 1'b1, 7'd7, 32'hABCDEF99, 4'b0011);
    checks++; if (dout_a !== 32'h34) begin errors++; $display("FAIL rdw_part_a actual=%h expected=34", dout_a); end
    checks++; if (dout_b !== 32'h0000EF99) begin errors++; $display("FAIL rdw_part_b actual=%h expected=0000ef99", dout_b); end
    cycle(1'b0, 1'b0, 1'b1, 7'd7, 32'h0, 4'h0);
    checks++; if (dout_a !== 32'h0000EF99) begin errors++; $display("FAIL rdw_part_after_a actual=%h expected=0000ef99", dout_a); end
  endtask

  task automatic test_out_of_range;
    cycle(1'b0, 1'b1, 1'b0, 7'd10, 32'h5A5A5A5A, 4'hF);
    cycle(1'b0, 1'b1, 1'b0, 7'd110, 32'hDEADBEEF, 4'hF);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL oor_wr_err_a actual=%b expected=1", err_a); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL oor_wr_err_b actual=%b expected=0", err_b); end
    idle(1);
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL oor_err_pulse_a actual=%b expected=0", err_a); end
    cycle(1'b0, 1'b0, 1'b1, 7'd110, 32'h0, 4'h0);
    checks++; if (valid_a !== 1'b0 || err_a !== 1'b1) begin errors++; $display("FAIL oor_rd_a actual=%b/%b expected=0/1", valid_a, err_a); end
    checks++; if (dout_a !== 32'h0000EF99) begin errors++; $display("FAIL oor_hold_a actual=%h expected=0000ef99", dout_a); end
    checks++; if (dout_b !== 32'hDEADBEEF || valid_b !== 1'b1) begin errors++; $display("FAIL rd110_b actual=%h/%b expected=deadbeef/1", dout_b, valid_b); end
    cycle(1'b0, 1'b0, 1'b1, 7'd10, 32'h0, 4'h0);
    checks++; if (dout_a !== 32'h5A5A5A5A) begin errors++; $display("FAIL no_alias_a actual=%h expected=5a5a5a5a", dout_a); end
    cycle(1'b0, 1'b0, 1'b1, 7'd99, 32'h0, 4'h0);
    checks++; if (valid_a !== 1'b1 || err_a !== 1'b0) begin errors++; $display("FAIL edge99_a actual=%b/%b expected=1/0", valid_a, err_a); end
    cycle(1'b0, 1'b0, 1'b1, 7'd100, 32'h0, 4'h0);
    checks++; if (valid_a !== 1'b0 || err_a !== 1'b1) begin errors++; $display("FAIL edge100_a actual=%b/%b expected=0/1", valid_a, err_a); end
  endtask

  task automatic test_back_to_back;
    int n_valid;
    n_valid = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 7'(i), 32'h0, 4'h0);
      if (valid_b === 1'b1) n_valid++;
      checks++;
      if (dout_b !== m_dout[1]) begin errors++; $display("FAIL burst_b addr=%0d actual=%h expected=%h", i, dout_b, m_dout[1]); end
    end
    checks++; if (n_valid != 16) begin errors++; $display("FAIL burst_count actual=%0d expected=16", n_valid); end
    for (int i = 0; i < 400; i++) begin
      logic        w, rd;
      logic [6:0]  a;
      logic [31:0] d, pred;
      logic [3:0]  be;
      w = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 127));
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      if (rd) begin
        pred = m_mem[1][a];
        if (w) begin
          for (int l = 0; l < 4; l++) if (be[l]) pred[8*l +: 8] = d[8*l +: 8];
        end
        exp_q.push_back(pred);
      end
      cycle(1'b0, w, rd, a, d, be);
      if (valid_b === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_b_extra_valid actual=%h expected=none", dout_b);
        end else begin
          pred = exp_q.pop_front();
          if (dout_b !== pred) begin errors++; $display("FAIL rand_b_data actual=%h expected=%h", dout_b, pred); end
        end
      end
      checks++;
      if (dout_a !== m_dout[0] || valid_a !== m_valid[0] || err_a !== m_err[0] || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL rand_a actual=%h/%b/%b/%b expected=%h/%b/%b/0", dout_a, valid_a, err_a, busy_a,
                 m_dout[0], m_valid[0], m_err[0]);
      end
      checks++;
      if (err_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL rand_b_flags actual=%b/%b expected=0/0", err_b, busy_b); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_b_missing_valid actual=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_clear;
    int n_busy;
    cycle(1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 4'h0);
    idle(50);
    cycle(1'b1, 1'b1, 1'b0, 7'd3, 32'hFFFFFFFF, 4'hF);
    checks++; if (busy_b !== 1'b1 || dout_b !== 32'h0 || valid_b !== 1'b0) begin errors++; $display("FAIL midrst_b actual=%b/%h/%b expected=1/0/0", busy_b, dout_b, valid_b); end
    n_busy = 1;
    for (int i = 0; i < 140; i++) begin
      cycle(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 7'd3 : 7'($urandom_range(0, 127)), 32'hFFFFFFFF, 4'hF);
      if (busy_b === 1'b1) n_busy++;
      if (m_clr[1] > 0) begin
        checks++;
        if (valid_b !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL busy_ignore_b actual=%b/%b expected=0/0", valid_b, err_b); end
      end
      if (m_clr[1] == 0) break;
    end
    checks++; if (n_busy != 128) begin errors++; $display("FAIL midrst_len actual=%0d expected=128", n_busy); end
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 7'd3, 32'h0, 4'h0);
    checks++; if (dout_b !== 32'h0 || valid_b !== 1'b1) begin errors++; $display("FAIL busy_write_dropped actual=%h/%b expected=0/1", dout_b, valid_b); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 7'd0; data_in = 32'h0; byte_en = 4'h0;
    for (int k = 0; k < 2; k++) m_clr[k] = 0;
    test_reset();
    test_write_read();
    test_byte_en();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
